// File: rtl/spi_sensor_sequencer.sv
// spi_sensor_sequencer: round-robin SPI sensor poller with per-transaction timeout and periodic auto sweeps.
// Defining TEMP_ALARM_EN adds sticky per-channel over-threshold alarms (alarm_thresh, alarm_clr, alarm).
module spi_sensor_sequencer #(
    parameter int N_CH = 4,
    parameter int DATA_W = 8,
    parameter int TIMEOUT_CYC = 1024,
    parameter int PERIOD_CYC = 50000,
    localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              auto_en,
    output logic              spi_start,
    output logic [CH_W-1:0]   spi_ch,
    input  logic [DATA_W-1:0] spi_data_in,
    input  logic              spi_data_ready,
    output logic [DATA_W-1:0] sample_out,
    output logic [CH_W-1:0]   sample_ch,
    output logic              data_valid,
    output logic              timeout_err,
    output logic              sweep_done,
    output logic              busy
`ifdef TEMP_ALARM_EN
    ,
    input  logic [DATA_W-1:0] alarm_thresh,
    input  logic              alarm_clr,
    output logic [N_CH-1:0]   alarm
`endif
);
    typedef enum logic [2:0] {IDLE, REQUEST, WAIT, DONE, ERR, GAP} state_t;
    localparam int CNT_W = $clog2((TIMEOUT_CYC > PERIOD_CYC ? TIMEOUT_CYC : PERIOD_CYC) + 1);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
    state_t state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CH_W-1:0] ch_d;
    logic last, timed_out, gap_end;
    always_comb begin
        last = spi_ch == LAST_CH;
        timed_out = cnt == CNT_W'(TIMEOUT_CYC - 1);
        gap_end = cnt == CNT_W'(PERIOD_CYC - 1);
        state_d = state;
        case (state)
            IDLE:      state_d = (start || auto_en) ? REQUEST : IDLE;
            REQUEST:   state_d = WAIT;
            WAIT:      state_d = spi_data_ready ? DONE : timed_out ? ERR : WAIT;
            DONE, ERR: state_d = !last ? REQUEST : auto_en ? GAP : IDLE;
            GAP:       state_d = !auto_en ? IDLE : gap_end ? REQUEST : GAP;
            default:   state_d = IDLE;
        endcase
        ch_d = (state == DONE || state == ERR) ? (last ? '0 : spi_ch + CH_W'(1)) : spi_ch;
        // the REQUEST cycle counts as the first cycle of the timeout window
        cnt_d = (state == WAIT || state == GAP) ? cnt + CNT_W'(1) : state == REQUEST ? CNT_W'(1) : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            spi_ch <= '0;
            sample_out <= '0;
            sample_ch <= '0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            spi_ch <= ch_d;
            if (state == WAIT && spi_data_ready) begin
                sample_out <= spi_data_in;
                sample_ch <= spi_ch;
            end
        end
    end
    assign spi_start = state == REQUEST;
    assign data_valid = state == DONE;
    assign timeout_err = state == ERR;
    assign sweep_done = (state == DONE || state == ERR) && last;
    assign busy = state != IDLE;
`ifdef TEMP_ALARM_EN
    logic [N_CH-1:0] alarm_set;
    assign alarm_set = (data_valid && sample_out > alarm_thresh) ? N_CH'(1) << sample_ch : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) alarm <= '0;
        else alarm <= (alarm & {N_CH{~alarm_clr}}) | alarm_set;
    end
`endif
endmodule

// File: tb/tb_spi_sensor_sequencer.sv
// tb_spi_sensor_sequencer: randomized sweeps against a cycle-level transaction model; a monitor
// pops predicted spi_start/data_valid/timeout_err events from a scoreboard queue.
module tb_spi_sensor_sequencer;
    localparam int N_CH = 4, DW = 12, TMO = 16, PERIOD = 20, CW = 2;
    localparam int EV_START = 0, EV_VALID = 1, EV_TMO = 2;
    typedef struct { int k; logic [DW-1:0] d; } plan_t;
    typedef struct { int kind; int cyc; int ch; logic [DW-1:0] data; int sch; bit done; } ev_t;
    logic clk = 0, rst, start, auto_en, spi_data_ready;
    logic [DW-1:0] spi_data_in, sample_out;
    logic [CW-1:0] spi_ch, sample_ch;
    logic spi_start, data_valid, timeout_err, sweep_done, busy;
`ifdef TEMP_ALARM_EN
    logic [DW-1:0] alarm_thresh;
    logic alarm_clr;
    logic [N_CH-1:0] alarm;
`endif
    int cyc = 0, checks = 0, errors = 0;
    plan_t plan_q[$];
    ev_t exp_q[$];
    int ks[N_CH];
    logic [DW-1:0] ds[N_CH];
    logic [DW-1:0] last_sample = '0;
    int last_ch = 0;

    spi_sensor_sequencer #(.N_CH(N_CH), .DATA_W(DW), .TIMEOUT_CYC(TMO), .PERIOD_CYC(PERIOD)) dut (
        .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .spi_start(spi_start),
        .spi_ch(spi_ch), .spi_data_in(spi_data_in), .spi_data_ready(spi_data_ready),
        .sample_out(sample_out), .sample_ch(sample_ch), .data_valid(data_valid),
        .timeout_err(timeout_err), .sweep_done(sweep_done), .busy(busy)
`ifdef TEMP_ALARM_EN
        , .alarm_thresh(alarm_thresh), .alarm_clr(alarm_clr), .alarm(alarm)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: ready on WAIT cycle k (1..TMO-1) gives data_valid k+1 cycles after
    // spi_start; k=0 means the engine stays silent and timeout_err lands TMO cycles after spi_start.
    task automatic add_sweep(input int t0, output int done);
        int t;
        ev_t e;
        bit ok;
        t = t0;
        for (int c = 0; c < N_CH; c++) begin
            ok = ks[c] >= 1 && ks[c] <= TMO - 1;
            e.kind = EV_START; e.cyc = t; e.ch = c; e.data = '0; e.sch = 0; e.done = 0;
            exp_q.push_back(e);
            if (ok) begin
                last_sample = ds[c];
                last_ch = c;
            end
            e.kind = ok ? EV_VALID : EV_TMO;
            e.cyc = ok ? t + ks[c] + 1 : t + TMO;
            e.data = last_sample; e.sch = last_ch; e.done = c == N_CH - 1;
            exp_q.push_back(e);
            plan_q.push_back('{ks[c], ds[c]});
            t = e.cyc + 1;
        end
        done = t - 1;
    endtask

    task automatic randomize_plan();
        int r;
        for (int c = 0; c < N_CH; c++) begin
            r = $urandom_range(0, 19);
            ks[c] = r > 15 ? 0 : r;
            ds[c] = DW'($urandom);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic run_sweep(input int poke);
        int done, t0;
        t0 = cyc + 1;
        start = 1;
        add_sweep(t0, done);
        @(negedge clk);
        start = 0;
        if (poke > 0) begin
            wait_cyc(t0 + poke);
            start = 1;
            @(negedge clk);
            start = 0;
        end
        wait_cyc(done + 1);
        chk("busy_after_sweep", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // SPI engine: answers each spi_start according to the next queued plan entry
    initial forever begin
        plan_t p;
        @(negedge clk);
        if (!rst && spi_start) begin
            p.k = 0; p.d = '0;
            if (plan_q.size() > 0) p = plan_q.pop_front();
            if (p.k > 0) begin
                repeat (p.k) @(negedge clk);
                spi_data_ready = 1;
                spi_data_in = p.d;
                @(negedge clk);
                spi_data_ready = 0;
            end
        end else spi_data_in = DW'($urandom);
    end

    initial forever begin
        ev_t e;
        int kind;
        @(negedge clk);
        if (!rst && sweep_done) chk("sweep_done_alone", data_valid | timeout_err, 1);
        if (!rst && (spi_start || data_valid || timeout_err)) begin
            kind = spi_start ? EV_START : data_valid ? EV_VALID : EV_TMO;
            chk("pulse_overlap", 32'(spi_start) + 32'(data_valid) + 32'(timeout_err), 1);
            chk("busy_on_event", busy, 1);
            if (exp_q.size() == 0) chk("unexpected_event", kind, 3);
            else begin
                e = exp_q.pop_front();
                chk("event_kind", kind, e.kind);
                chk("event_cycle", cyc, e.cyc);
                if (e.kind != EV_VALID) chk("spi_ch", spi_ch, e.ch);
                if (e.kind != EV_START) begin
                    chk("sample_out", sample_out, e.data);
                    chk("sample_ch", sample_ch, e.sch);
                    chk("sweep_done", sweep_done, e.done);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, done;
        int starts[3], dones[3];
        rst = 1; start = 0; auto_en = 0; spi_data_ready = 0; spi_data_in = '0;
`ifdef TEMP_ALARM_EN
        alarm_thresh = 12'h102; alarm_clr = 0;
`endif
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_spi_start", spi_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_sweep_done", sweep_done, 0);
        chk("rst_spi_ch", spi_ch, 0);
        chk("rst_sample_out", sample_out, 0);
        chk("rst_sample_ch", sample_ch, 0);
        ks = '{3, 3, 3, 3};
        ds = '{12'h100, 12'h101, 12'h102, 12'h103};
        run_sweep(0);
`ifdef TEMP_ALARM_EN
        chk("alarm_after_sweep", alarm, 4'b1000);
        alarm_clr = 1;
        @(negedge clk);
        alarm_clr = 0;
        chk("alarm_cleared", alarm, 4'b0000);
        alarm_thresh = '1;
`endif
        ks = '{3, 3, 0, 3};
        ds = '{12'h100, 12'h101, 12'h1aa, 12'h103};
        run_sweep(0);
        ks = '{15, 4, 15, 1};
        ds = '{12'h5a5, 12'h0ff, 12'hfff, 12'h001};
        run_sweep(5);
        for (int s = 0; s < 6; s++) begin
            randomize_plan();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_sweep(0);
        end
        // auto_en dropped while waiting in the gap
        auto_en = 1;
        randomize_plan();
        add_sweep(cyc + 1, done);
        wait_cyc(done + 5);
        chk("busy_in_gap", busy, 1);
        auto_en = 0;
        @(negedge clk);
        chk("gap_exit_idle", busy, 0);
        chk("gap_queue_drained", exp_q.size(), 0);
        // continuous sweeps, auto_en dropped during the third
        @(negedge clk);
        auto_en = 1;
        t0 = cyc + 1;
        for (int s = 0; s < 3; s++) begin
            randomize_plan();
            starts[s] = t0;
            add_sweep(t0, dones[s]);
            t0 = dones[s] + PERIOD + 1;
        end
        wait_cyc(starts[2] + 2);
        auto_en = 0;
        wait_cyc(dones[2] + 1);
        chk("auto_stop_busy", busy, 0);
        chk("auto_queue_drained", exp_q.size(), 0);
        repeat (PERIOD + 10) @(negedge clk);
        chk("auto_no_restart", busy, 0);
        // reset while waiting on channel 1; its ready arrives after reset is released
        ks = '{2, 10, 3, 3};
        ds = '{12'h777, 12'h888, 12'h999, 12'haaa};
        t0 = cyc + 1;
        start = 1;
        add_sweep(t0, done);
        @(negedge clk);
        start = 0;
        wait_cyc(t0 + 7);
        chk("pre_rst_spi_ch", spi_ch, 1);
        rst = 1;
        #1;
        chk("mid_rst_spi_start", spi_start, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data_valid", data_valid, 0);
        chk("mid_rst_timeout_err", timeout_err, 0);
        chk("mid_rst_sweep_done", sweep_done, 0);
        chk("mid_rst_spi_ch", spi_ch, 0);
        chk("mid_rst_sample_out", sample_out, 0);
        chk("mid_rst_sample_ch", sample_ch, 0);
        exp_q.delete();
        plan_q.delete();
        last_sample = '0;
        last_ch = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        wait_cyc(t0 + 25);
        chk("late_ready_busy", busy, 0);
        chk("late_ready_sample", sample_out, 0);
        chk("final_queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
